// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, operand select encodings and the
// buffered operand-stage entry payload.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_REG_AW = 5;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADDU = 4'h1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'h2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUBU = 4'h3;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'h4;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'h5;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'h6;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'h7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'h8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'h9;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'hA;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'hB;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'hC;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'hD;

  localparam logic A_SEL_RS    = 1'b0;
  localparam logic A_SEL_SHAMT = 1'b1;
  localparam logic B_SEL_RT    = 1'b0;
  localparam logic B_SEL_IMM   = 1'b1;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [ALU_REG_AW-1:0] rd;
    logic                  wr_en;
  } entry_t;

endpackage

// File: rtl/ex_skid_buffer.sv
// Generic two-entry FIFO skid buffer; slot0 is always the head so the
// output payload comes straight from a register.
module ex_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count, count_n;
  logic [WIDTH-1:0] slot0, slot0_n;
  logic [WIDTH-1:0] slot1, slot1_n;
  logic             rdy_q, vld_q;
  logic             accept, pop;

  assign accept    = in_valid & rdy_q & ~flush;
  assign pop       = vld_q & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = slot0;

  // Next occupancy and slot contents; flush overrides accept and pop.
  always_comb begin
    count_n = count;
    slot0_n = slot0;
    slot1_n = slot1;
    if (flush) begin
      count_n = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          count_n = count + 2'd1;
          if (count == 2'd0) slot0_n = in_data;
          else               slot1_n = in_data;
        end
        2'b01: begin
          count_n = count - 2'd1;
          slot0_n = slot1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0_n = in_data;
          end else begin
            slot0_n = slot1;
            slot1_n = in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      count <= count_n;
      slot0 <= slot0_n;
      slot1 <= slot1_n;
      rdy_q <= (count_n < 2'd2);
      vld_q <= (count_n != 2'd0);
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand stage: forwarding resolution, A/B operand
// formation and a two-entry skid buffer in front of the ALU.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_control,
  input  logic              in_a_sel,
  input  logic              in_b_sel,
  input  logic              in_imm_sext,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm16,
  input  logic [4:0]        in_shamt,
  input  logic              in_wr_en,
  input  logic              fwd_ex_valid,
  input  logic [REG_AW-1:0] fwd_ex_addr,
  input  logic [DATA_W-1:0] fwd_ex_data,
  input  logic              fwd_mem_valid,
  input  logic [REG_AW-1:0] fwd_mem_addr,
  input  logic [DATA_W-1:0] fwd_mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_wr_en
);

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic [DATA_W-1:0]  rs_val, rt_val, imm_ext, a_val, b_val;
  entry_t             in_entry, head;
  logic [ENTRY_W-1:0] head_bits;

  // EX result beats MEM result; register 0 is hard-wired to zero.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_v,
    input logic [REG_AW-1:0] ex_a,
    input logic [DATA_W-1:0] ex_d,
    input logic              mem_v,
    input logic [REG_AW-1:0] mem_a,
    input logic [DATA_W-1:0] mem_d
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    if (addr == '0)                       val = '0;
    else if (ex_v && (ex_a == addr))      val = ex_d;
    else if (mem_v && (mem_a == addr))    val = mem_d;
    return val;
  endfunction

  always_comb begin
    rs_val  = resolve(in_rs_addr, in_rs_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                      fwd_mem_valid, fwd_mem_addr, fwd_mem_data);
    rt_val  = resolve(in_rt_addr, in_rt_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                      fwd_mem_valid, fwd_mem_addr, fwd_mem_data);
    imm_ext = in_imm_sext ? {{(DATA_W-16){in_imm16[15]}}, in_imm16}
                          : {{(DATA_W-16){1'b0}}, in_imm16};
    a_val   = (in_a_sel == A_SEL_SHAMT) ? DATA_W'(in_shamt) : rs_val;
    b_val   = (in_b_sel == B_SEL_IMM) ? imm_ext : rt_val;
  end

  always_comb begin
    in_entry       = '0;
    in_entry.a     = ALU_DATA_W'(a_val);
    in_entry.b     = ALU_DATA_W'(b_val);
    in_entry.ctrl  = in_alu_control;
    in_entry.rd    = ALU_REG_AW'(in_rd_addr);
    in_entry.wr_en = in_wr_en;
  end

  ex_skid_buffer #(.WIDTH(ENTRY_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_bits)
  );

  assign head        = entry_t'(head_bits);
  assign alu_a       = DATA_W'(head.a);
  assign alu_b       = DATA_W'(head.b);
  assign alu_control = head.ctrl;
  assign out_rd_addr = REG_AW'(head.rd);
  assign out_wr_en   = head.wr_en;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode-to-execute operand stage directly upstream of the ALU. Accepts one decoded instruction per cycle, resolves forwarding against the two downstream result stages, and forms the ALU's A/B operands and 4-bit ALU control. Results are buffered in a two-entry skid buffer with valid/ready handshakes on both sides. A synchronous flush discards all buffered work.

## Interface
- `DATA_W`, 32: operand width.
- `REG_AW`, 5: register address width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; discards buffer contents and the current input.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_alu_control` in 4: ALU op code (see Operation).
- `in_a_sel` in 1: 0 = rs data, 1 = shamt.
- `in_b_sel` in 1: 0 = rt data, 1 = immediate.
- `in_imm_sext` in 1: 1 = sign-extend imm16, 0 = zero-extend.
- `in_rs_addr`, `in_rt_addr`, `in_rd_addr` in REG_AW: source and destination registers.
- `in_rs_data`, `in_rt_data` in DATA_W: register file read data.
- `in_imm16` in 16, `in_shamt` in 5, `in_wr_en` in 1: immediate, shift amount, destination write enable.
- `fwd_ex_valid` in 1, `fwd_ex_addr` in REG_AW, `fwd_ex_data` in DATA_W: ALU-stage result.
- `fwd_mem_valid` in 1, `fwd_mem_addr` in REG_AW, `fwd_mem_data` in DATA_W: memory-stage result.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `alu_a`, `alu_b` out DATA_W; `alu_control` out 4; `out_rd_addr` out REG_AW; `out_wr_en` out 1.

## Operation
- ALU control codes: ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, NOR 7, SLT 8, SLTU 9, SLL A, SRL B, SRA C, LUI D. Codes E and F are forwarded unchanged.
- Forwarded rs/rt values:
  - EX match (valid, addr equal, addr ≠ 0) has priority.
  - Otherwise MEM match.
  - Otherwise register data.
  - Address 0 always yields 0, regardless of `in_*_data`.
- `alu_a` = in_a_sel ? {27'b0, in_shamt} : fwd_rs. The ALU shifts B by A, so variable shifts use rs and constant shifts use shamt.
- `alu_b` = in_b_sel ? ext(imm16) : fwd_rt. For LUI, the ALU consumes `alu_b[15:0]`, so the extension mode does not matter.
- Operands are resolved combinationally in the accept cycle and stored. Later changes on the fwd_* ports do not affect entries already buffered.
- Buffer: two entries, FIFO order, occupancy count 0..2.
  - `in_ready` = (count < 2), registered.
  - `out_valid` = (count ≠ 0).
  - Outputs always show the head entry.
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- Accept and pop in the same cycle leave count unchanged; order is preserved.
- `flush`: count → 0 next cycle and the same-cycle input is dropped. Flush has priority over accept and pop.
- Reset values: count 0, out_valid 0, in_ready 1, all data outputs 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first accept is possible in the first cycle after deassertion.

## Timing
- Latency: accept in cycle N gives `out_valid` in cycle N+1 with that entry at the head.
- Throughput: 1 per cycle while `out_ready` is held high.
- `in_ready` does not depend combinationally on `out_ready`. Backpressure reaches upstream one cycle late; the second entry absorbs the difference.
- Full (count 2) with pop: `in_ready` rises in the next cycle, not the same cycle.
- Empty with accept: no bypass; `out_valid` stays 0 in the accept cycle.
- Outputs are stable while out_valid & !out_ready. They change only after a pop or flush.

## Structure
- Shared package `alu_pkg`: ALU control constants 0–D, `A_SEL_RS`/`A_SEL_SHAMT`, `B_SEL_RT`/`B_SEL_IMM`, and a packed entry struct {a, b, ctrl, rd, wr_en}.
- Sub-module `ex_skid_buffer`: a generic two-entry buffer parameterised by the entry width, holding the count, handshake and flush logic.
- Top level contains the forwarding mux, operand selection, extension logic and the buffer instance.

## Test plan
- Back-to-back ADDU with rs = 3 (data 5), rt = 4 (data 7), out_ready = 1: alu_a = 5, alu_b = 7, ctrl = 1, one cycle after accept; one output every cycle.
- Forwarding priority: rs = 8 with fwd_ex (8, 0xAAAA0000) and fwd_mem (8, 0x11) both valid gives alu_a = 0xAAAA0000. Same case with fwd_ex_valid = 0 gives 0x11. rs = 0 with both forwards at address 0 gives alu_a = 0.
- SLL with shamt = 4 and a_sel = 1 gives alu_a = 4. ADDI with imm16 = 0xFFFF: sext gives alu_b = 0xFFFFFFFF; zext gives 0x0000FFFF.
- Backpressure: out_ready = 0 with 3 inputs offered gives count 2, in_ready = 0, and the third input held upstream. Then out_ready = 1 drains the entries in order; in_ready = 1 one cycle after the first pop.
- Flush while count = 2 and in_valid = 1: next cycle out_valid = 0, in_ready = 1; no entry is ever emitted.
- rst_n pulsed low while count = 1: out_valid, alu_a, alu_b and ctrl go to 0 immediately; the first accept after release reappears at the output one cycle later.
